// File: rtl/serial_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   Revision: 1.0
// ----------------------------------------------------------------------------
package serial_pkg;

  // Operation sequencing: wait, shift one bit per clock, present result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// full_sub
//   One-bit full subtractor: diff = x - y - bin, with borrow out.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  // Borrow when y exceeds x, or when they are equal and a borrow arrives.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_sub
//   Bit-serial WIDTH-bit subtractor (a - b - bi), LSB first, with a
//   start/busy/done handshake. Result and borrow are held until the next
//   operation completes.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module serial_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             diff;
  logic             bout;
  logic             last_bit;
  logic             load;

  full_sub u_full_sub (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .diff (diff),
    .bout (bout)
  );

  // Result register after this bit lands in the MSB; written as a shift/or
  // so that the same expression also covers WIDTH == 1.
  assign r_nxt    = (r_sh >> 1) | (WIDTH'(diff) << (WIDTH - 1));
  assign last_bit = (cnt == LAST_CNT);
  // A new operation can be accepted from IDLE or straight out of DONE.
  assign load     = start && (state != SHIFT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shifters, borrow flop, bit counter and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bo   <= 1'b0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bi;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nxt;
      br   <= bout;
      cnt  <= cnt + 1'b1;
      if (last_bit) begin
        d  <= r_nxt;
        bo <= bout;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_sub
//   Scoreboard bench for serial_sub: the driver pushes arithmetic results of
//   accepted operations, a negedge monitor checks the handshake and the held
//   result every cycle.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_serial_sub;
  import serial_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } res_t;

  res_t         sbq[$];
  int           rem       = 0;     // cycles of work left in the model
  bit           exp_done  = 1'b0;
  logic [W-1:0] exp_d     = '0;
  logic         exp_bo    = 1'b0;
  int           n_cmp     = 0;
  int           n_err     = 0;

  // Plain integer arithmetic: {bo, d} is the two's-complement a - b - bi.
  function automatic res_t ref_sub(input int x, input int y, input int z);
    res_t r;
    int   v;
    v    = x - y - z;
    r.d  = W'(v);
    r.bo = (v < 0);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the timing model, then settle 1 time unit.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc      = start && rst_n && (rem == 0);
    exp_done = (rem == 1);
    if (acc) begin
      sbq.push_back(ref_sub(int'(a), int'(b), int'(bi)));
      rem = W;
    end else if (rem > 0) begin
      rem--;
    end
    #1;
  endtask

  task automatic model_reset();
    rem      = 0;
    exp_done = 1'b0;
    exp_d    = '0;
    exp_bo   = 1'b0;
    sbq.delete();
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi);
    int g;
    g = 0;
    while (rem != 0 && g < 50) begin
      tick();
      g++;
    end
    a = xa; b = xb; bi = xbi; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((rem != 0 || sbq.size() != 0) && g < 100) begin
      tick();
      g++;
    end
    check("drain_timeout", g, (g < 100) ? g : 0);
    check("sb_empty", sbq.size(), 0);
  endtask

  // Monitor: handshake every cycle, result taken from the scoreboard when due.
  always @(negedge clk) begin
    check("busy", busy, (rem > 0) ? 1 : 0);
    check("done", done, exp_done ? 1 : 0);
    if (exp_done && rst_n) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        res_t e;
        e      = sbq.pop_front();
        exp_d  = e.d;
        exp_bo = e.bo;
      end
    end
    check("d", d, exp_d);
    check("bo", bo, exp_bo);
  end

  initial begin
    int bc;
    int dc;
    int k;
    int g;
    logic [W-1:0] set_a [4];
    logic [W-1:0] set_b [4];
    logic         set_i [4];

    rst_n = 1'b0; start = 1'b1; a = '1; b = '0; bi = 1'b1;
    model_reset();
    repeat (4) tick();
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();

    // Directed values, including extremes.
    op(4'b0101, 4'b0011, 1'b0); drain();
    op(4'b0011, 4'b0101, 1'b0); drain();
    op(4'b1010, 4'b0101, 1'b1); drain();
    op(4'b0000, 4'b0000, 1'b1); drain();
    op(4'b1111, 4'b1111, 1'b0); drain();
    op(4'b1111, 4'b0000, 1'b0); drain();

    // Start during SHIFT is ignored and operands may change freely.
    bc = 0; dc = 0;
    a = 4'b0101; b = 4'b0011; bi = 1'b0; start = 1'b1;
    tick(); bc += busy; dc += done;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    tick(); bc += busy; dc += done;
    a = 4'b1111; b = 4'b0000; start = 1'b1;
    tick(); bc += busy; dc += done;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      tick(); bc += busy; dc += done;
    end
    check("busy_cycles", bc, W);
    check("done_pulses", dc, 1);
    check("ignore_d", d, 2);
    drain();

    // Back-to-back with start held high.
    set_a = '{4'b0101, 4'b0011, 4'b1001, 4'b0000};
    set_b = '{4'b0011, 4'b0101, 4'b0110, 4'b0001};
    set_i = '{1'b0, 1'b1, 1'b1, 1'b0};
    start = 1'b1;
    for (int s = 0; s < 4; s++) begin
      a = set_a[s]; b = set_b[s]; bi = set_i[s];
      g = 0;
      while (rem != W && g < 20) begin
        tick();
        g++;
      end
      check("b2b_accept", (g < 20) ? 1 : 0, 1);
      if (s < 3) tick();
    end
    start = 1'b0;
    drain();

    // Randomized traffic, including start noise while busy.
    for (int i = 0; i < 200; i++) begin
      start = 1'($urandom);
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      tick();
    end
    start = 1'b0;
    drain();

    // Reset mid-operation, then a clean operation.
    op(4'b1010, 4'b0011, 1'b1);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    op(4'b1000, 4'b0001, 1'b0);
    drain();
    check("post_rst_d", d, 7);
    check("post_rst_bo", bo, 0);

    k = n_cmp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", k, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in. Computes a - b - bi one bit per clock, LSB first.
- The subtract-direction counterpart to the team's combinational 4-bit parallel adder. It trades latency for a single 1-bit full-subtractor cell.
- Driven by a start/done handshake from a control FSM or testbench.
- Result and borrow-out are registered and held until the next operation completes.

Parameters:
- WIDTH, 4, operand and result width in bits (>=1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on the rising edge of clk.
- a  input  WIDTH  minuend; sampled only on the edge where start is accepted.
- b  input  WIDTH  subtrahend; sampled only on the edge where start is accepted.
- bi  input  1  borrow-in; sampled only on the edge where start is accepted.
- d  output  WIDTH  difference (a - b - bi) mod 2^WIDTH; registered.
- bo  output  1  borrow-out: 1 when a < b + bi (unsigned); registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking the cycle in which new d/bo are valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - d=0, bo=0, busy=0, done=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - An in-flight operation is abandoned; no done pulse follows reset release.
- States:
  - IDLE: busy=0, done=0.
    - start=1 → load a_sh=a, b_sh=b, br=bi, cnt=0, go to SHIFT.
  - SHIFT: busy=1, done=0. On each edge:
    - diff = a_sh[0]^b_sh[0]^br.
    - br <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
    - r_sh <= {diff, r_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1.
    - cnt++.
    - On the edge where cnt==WIDTH-1 (the last bit): d <= final r_sh including this bit, bo <= final borrow, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - Next edge: start=1 → reload and go to SHIFT (back-to-back operation); else go to IDLE.
- Latency:
  - start sampled at edge E0.
  - Bits processed at edges E1..EWIDTH.
  - done=1 and new d/bo valid during the cycle after EWIDTH.
  - Throughput is one operation per WIDTH+1 cycles.
- start while in SHIFT is ignored; operands are not re-sampled.
- a, b and bi may change freely after the accept edge without affecting the result.
- d/bo change only on entry to DONE. They hold their value through IDLE and the following operation until the next DONE.
- Width rules:
  - d is the modulo-2^WIDTH difference.
  - bo is the final borrow, so {bo, d} is the (WIDTH+1)-bit two's-complement result.
- Edge case: with WIDTH=1, SHIFT lasts exactly one cycle.
- Reset asserted in any state, including DONE, forces IDLE within the same cycle (asynchronous). done drops immediately.

Decomposition:
- Shared package serial_pkg holds:
  - state enum {IDLE, SHIFT, DONE}.
  - Default WIDTH constant.
  - Counter-width helper ($clog2(WIDTH), minimum 1).
- Sub-module full_sub (purely combinational):
  - Inputs x, y, bin; outputs diff, bout.
  - The counterpart of the team's full-adder cell; instantiated once in the SHIFT datapath.
- Top level serial_sub contains the FSM, shift registers, counter and output registers.

Test Plan:
- Reset: hold rst_n=0, drive start=1 → d=0000, bo=0, busy=0, done=0 throughout. Release reset → no done pulse until a start is accepted.
- Basic subtractions at WIDTH=4, one operation each:
  - a=0101, b=0011, bi=0 → done after 5 cycles; d=0010, bo=0.
  - a=0011, b=0101, bi=0 → d=1110, bo=1.
  - a=1010, b=0101, bi=1 → d=0100, bo=0.
- Extremes:
  - a=0000, b=0000, bi=1 → d=1111, bo=1.
  - a=1111, b=1111, bi=0 → d=0000, bo=0.
  - a=1111, b=0000, bi=0 → d=1111, bo=0.
- Busy-ignore and operand stability: start 0101-0011. Two cycles later pulse start with a=1111, b=0000 and change a/b every cycle → single done, d=0010. busy high for exactly 4 cycles.
- Back-to-back: hold start=1 continuously with alternating operand sets → done pulses every 5 cycles. d/bo match each expected result. busy is low only in the done cycle.
- Reset mid-operation: assert rst_n=0 two cycles into SHIFT → outputs zero immediately. After release, a new start 1000-0001 bi=0 → d=0111, bo=0, with no stale done pulse.
